// File: rtl/bp_btb_wr_arbiter.sv
// bp_btb_wr_arbiter: shares the single BTB write port between the executor
// (resolved jumps, absolute priority, one-entry hold) and the two pre-decoder
// lanes (predicted jumps, buffered in a QDEPTH-entry FIFO). The write port is
// registered and only changes at a load boundary (port idle or write accepted).
// Optional build macro: BP_WR_DEDUP_EN -- silently discard pre-decoder requests
// whose pc[RISCV_ARCH-1:1] is already queued, being written, or duplicated by
// lane0 in the same cycle.
module bp_btb_wr_arbiter #(
    parameter int RISCV_ARCH = 64,
    parameter int QDEPTH     = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_e_jmp,
    input  logic [RISCV_ARCH-1:0]   i_e_pc,
    input  logic [RISCV_ARCH-1:0]   i_e_npc,
    input  logic [1:0]              i_pd_jmp,
    input  logic [RISCV_ARCH-1:0]   i_pd_pc0,
    input  logic [RISCV_ARCH-1:0]   i_pd_npc0,
    input  logic [RISCV_ARCH-1:0]   i_pd_pc1,
    input  logic [RISCV_ARCH-1:0]   i_pd_npc1,
    input  logic                    i_btb_ready,
    output logic                    o_we,
    output logic [RISCV_ARCH-1:0]   o_we_pc,
    output logic [RISCV_ARCH-1:0]   o_we_npc,
    output logic                    o_we_exec,
    output logic [$clog2(QDEPTH):0] o_q_count,
    output logic [7:0]              o_drop_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_PDEC = 2'd2;

    // Output register / FSM
    logic [1:0]            state_q, state_d;
    logic [RISCV_ARCH-1:0] we_pc_q, we_pc_d;
    logic [RISCV_ARCH-1:0] we_npc_q, we_npc_d;

    // Executor holding register
    logic                  hold_v_q, hold_v_d;
    logic [RISCV_ARCH-1:0] hold_pc_q, hold_pc_d;
    logic [RISCV_ARCH-1:0] hold_npc_q, hold_npc_d;

    // Pre-decoder FIFO
    logic [RISCV_ARCH-1:0] mem_pc  [QDEPTH];
    logic [RISCV_ARCH-1:0] mem_npc [QDEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [7:0]            drop_q, drop_d;

    // Per-cycle control
    logic          load;
    logic          pop;
    logic          push0;
    logic          push1;
    logic [PW-1:0] wr_idx1;
    logic [CW-1:0] space;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;
    logic          dup0;
    logic          dup1;

    assign o_we       = (state_q != ST_IDLE);
    assign o_we_exec  = (state_q == ST_EXEC);
    assign o_we_pc    = we_pc_q;
    assign o_we_npc   = we_npc_q;
    assign o_q_count  = count_q;
    assign o_drop_cnt = drop_q;

`ifdef BP_WR_DEDUP_EN
    logic [QDEPTH-1:0] ent_valid;

    // Flag lane requests that duplicate queued, in-flight or same-cycle lane0 pcs
    always_comb begin
        dup0      = 1'b0;
        dup1      = 1'b0;
        ent_valid = '0;
        for (int i = 0; i < QDEPTH; i++) begin
            ent_valid[i] = (CW'(PW'(PW'(i) - rd_ptr_q)) < count_q);
            if (ent_valid[i] && mem_pc[i][RISCV_ARCH-1:1] == i_pd_pc0[RISCV_ARCH-1:1])
                dup0 = 1'b1;
            if (ent_valid[i] && mem_pc[i][RISCV_ARCH-1:1] == i_pd_pc1[RISCV_ARCH-1:1])
                dup1 = 1'b1;
        end
        if (o_we && we_pc_q[RISCV_ARCH-1:1] == i_pd_pc0[RISCV_ARCH-1:1])
            dup0 = 1'b1;
        if (o_we && we_pc_q[RISCV_ARCH-1:1] == i_pd_pc1[RISCV_ARCH-1:1])
            dup1 = 1'b1;
        if (i_pd_jmp[0] && i_pd_pc0[RISCV_ARCH-1:1] == i_pd_pc1[RISCV_ARCH-1:1])
            dup1 = 1'b1;
    end
`else
    assign dup0 = 1'b0;
    assign dup1 = 1'b0;
`endif

    // Select the next write source at a load boundary; capture late executor requests
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d    = state_q;
        we_pc_d    = we_pc_q;
        we_npc_d   = we_npc_q;
        hold_v_d   = hold_v_q;
        hold_pc_d  = hold_pc_q;
        hold_npc_d = hold_npc_q;
        pop        = 1'b0;

        // A flush cancels a stalled speculative write, so that case reloads too.
        load = (state_q == ST_IDLE) || i_btb_ready ||
               (i_flush && state_q == ST_PDEC);

        if (load) begin
            if (i_e_jmp) begin
                state_d  = ST_EXEC;
                we_pc_d  = i_e_pc;
                we_npc_d = i_e_npc;
            end else if (hold_v_q) begin
                state_d  = ST_EXEC;
                we_pc_d  = hold_pc_q;
                we_npc_d = hold_npc_q;
                hold_v_d = 1'b0;
            end else if (!i_flush && count_q != '0) begin
                state_d  = ST_PDEC;
                we_pc_d  = mem_pc[rd_ptr_q];
                we_npc_d = mem_npc[rd_ptr_q];
                pop      = 1'b1;
            end else begin
                state_d  = ST_IDLE;
                we_pc_d  = '0;
                we_npc_d = '0;
            end
        end else if (i_e_jmp) begin
            // Latest executor request wins; an older held one is dropped.
            hold_v_d   = 1'b1;
            hold_pc_d  = i_e_pc;
            hold_npc_d = i_e_npc;
        end
    end

    // FIFO push/drop decisions, pointer and occupancy update, saturating drop count
    always_comb begin
        space    = CW'(QDEPTH) - count_q + CW'(pop);
        push0    = 1'b0;
        push1    = 1'b0;
        drop_inc = 2'd0;

        if (!i_flush) begin
            if (i_pd_jmp[0] && !dup0) begin
                if (space != '0) push0 = 1'b1;
                else             drop_inc = drop_inc + 2'd1;
            end
            if (i_pd_jmp[1] && !dup1) begin
                if (space > CW'(push0)) push1 = 1'b1;
                else                    drop_inc = drop_inc + 2'd1;
            end
        end

        wr_idx1 = push0 ? wr_ptr_q + PW'(1) : wr_ptr_q;

        if (i_flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
            count_d  = count_q - CW'(pop) + CW'(push0) + CW'(push1);
        end

        drop_sum = {1'b0, drop_q} + {7'b0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            we_pc_q    <= '0;
            we_npc_q   <= '0;
            hold_v_q   <= 1'b0;
            hold_pc_q  <= '0;
            hold_npc_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            we_pc_q    <= we_pc_d;
            we_npc_q   <= we_npc_d;
            hold_v_q   <= hold_v_d;
            hold_pc_q  <= hold_pc_d;
            hold_npc_q <= hold_npc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
        end
    end

    // FIFO storage writes; lane0 lands before lane1
    // NOTE: storage is not reset; an entry is only read once count_q marks it valid.
    always_ff @(posedge i_clk) begin
        if (push0) begin
            mem_pc[wr_ptr_q]  <= i_pd_pc0;
            mem_npc[wr_ptr_q] <= i_pd_npc0;
        end
        if (push1) begin
            mem_pc[wr_idx1]  <= i_pd_pc1;
            mem_npc[wr_idx1] <= i_pd_npc1;
        end
    end

endmodule

// File: doc/bp_btb_wr_arbiter.md
Name: bp_btb_wr_arbiter

Overview:
Arbitrates the single BTB write port between the executor (resolved jumps) and the two pre-decoder lanes (predicted jumps).
- Executor requests have absolute priority and use a one-entry holding register.
- Pre-decoder requests are buffered in a small FIFO and drained when the port is free.
- Sits between the branch-predictor front logic and the BTB, replacing the direct combinational write-select. Drives a registered, ready-qualified write port.

Parameters:
RISCV_ARCH, 64, address width
QDEPTH, 4, pre-decoder FIFO depth (power of 2, >=2)

Ports:
i_clk  in  1  CPU clock
i_rst  in  1  reset, asynchronous, active-high
i_flush  in  1  flush pipeline: discard speculative pre-decoder work
i_e_jmp  in  1  executor jump resolved
i_e_pc  in  RISCV_ARCH  executor jump pc
i_e_npc  in  RISCV_ARCH  executor jump target
i_pd_jmp  in  2  pre-decoder lane jump valid (bit0 = lane0)
i_pd_pc0  in  RISCV_ARCH  lane0 pc
i_pd_npc0  in  RISCV_ARCH  lane0 target
i_pd_pc1  in  RISCV_ARCH  lane1 pc
i_pd_npc1  in  RISCV_ARCH  lane1 target
i_btb_ready  in  1  BTB accepts write this cycle
o_we  out  1  write request valid
o_we_pc  out  RISCV_ARCH  write pc
o_we_npc  out  RISCV_ARCH  write target
o_we_exec  out  1  current write is executor-sourced (sets BTB exec bit)
o_q_count  out  $clog2(QDEPTH)+1  FIFO occupancy
o_drop_cnt  out  8  saturating count of pre-decoder requests dropped on full FIFO

Behaviour:
- Reset: o_we=0, o_we_pc=0, o_we_npc=0, o_we_exec=0, o_q_count=0, o_drop_cnt=0, exec hold empty, FSM=IDLE.
- Accept: a write completes when o_we && i_btb_ready. While o_we=1 and i_btb_ready=0, all o_we_* outputs stay stable.
- Output register loads when !o_we || i_btb_ready. Source priority:
  1. incoming i_e_jmp
  2. exec hold
  3. FIFO head
  4. none (o_we=0)
- Latency: an executor request reaches o_we the next cycle if the port is free.
- Exec hold:
  - i_e_jmp arriving when the output register cannot load is captured in the hold.
  - A newer i_e_jmp overwrites the hold; latest wins, and the older one is silently lost.
- FSM:
  - IDLE (o_we=0) -> EXEC | PDEC on load.
  - EXEC (o_we_exec=1) -> EXEC | PDEC | IDLE after accept, per the priority above.
  - PDEC (o_we_exec=0) -> same transitions.
  - Executor preemption occurs only at a load boundary; an un-accepted PDEC write is never replaced mid-stall.
- FIFO push:
  - Lane0 is pushed before lane1 in the same cycle.
  - Free space = QDEPTH - count + pop, where pop = FIFO head loaded this cycle.
  - A lane that finds no space is dropped and o_drop_cnt increments by 1 per dropped lane, saturating at 255.
  - Pointers wrap modulo QDEPTH.
- Pop: the FIFO head is popped when it is loaded into the output register.
- Flush:
  - FIFO is cleared and same-cycle pd pushes are discarded.
  - An un-accepted PDEC output is cancelled (o_we=0 next cycle unless exec is pending).
  - EXEC output and exec hold are preserved.
  - Flush does not clear o_drop_cnt.
- Reset mid-operation: everything returns to reset values immediately; no write completes.

Optional Feature:
BP_WR_DEDUP_EN
- Defined: a pd lane request is discarded without incrementing o_drop_cnt when its pc[RISCV_ARCH-1:1] matches any of:
  - a valid FIFO entry
  - the current o_we_pc while o_we=1
  - lane0's pc in the same cycle (lane1 only)
- Not defined: every pd request is pushed, subject to space.

Test Plan:
1. Reset, then i_e_jmp=1, pc=0x1000, npc=0x2000, ready=1 -> next cycle o_we=1, o_we_exec=1, o_we_pc=0x1000, o_we_npc=0x2000; following cycle o_we=0.
2. ready=0; pd lanes 0x100->0x200 and 0x104->0x300 pushed; o_q_count=2 -> raise ready -> writes 0x100 then 0x104 in order, o_we_exec=0.
3. PDEC write 0x100 stalled (ready=0) + i_e_jmp 0x40->0x80 -> o_we_pc stays 0x100 until ready; next write is 0x40 with o_we_exec=1; queued pd entries follow.
4. ready=0, fill FIFO to 4, then push both lanes -> o_q_count=4, o_drop_cnt=2; repeat 130 cycles -> o_drop_cnt saturates at 255.
5. Queue holding 3 entries, PDEC stalled, exec hold filled; assert i_flush -> o_q_count=0, PDEC cancelled, exec write appears once ready=1.
6. With BP_WR_DEDUP_EN defined: both lanes pc=0x500 -> o_q_count=1, o_drop_cnt unchanged. Without the macro -> o_q_count=2.
